// File: rtl/tmds_word_align.sv
// TMDS receive word aligner: finds the 10-bit symbol boundary by hunting for control tokens,
// then decodes aligned symbols into video bytes / control bits through a two-stage pipeline.
module tmds_word_align #(
  parameter int unsigned LOCK_CNT       = 8,
  parameter int unsigned SEARCH_TIMEOUT = 32,
  parameter int unsigned LOSS_TIMEOUT   = 4096
) (
  input  logic       clk_pix,
  input  logic       rst_n,
  input  logic [9:0] sym_in,
  input  logic       sym_valid,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       out_valid,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int unsigned TOK_W   = $clog2(LOCK_CNT + 1);
  localparam int unsigned DWELL_W = $clog2(SEARCH_TIMEOUT + 1);
  localparam int unsigned GAP_W   = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [TOK_W-1:0]   TOK_MAX   = TOK_W'(LOCK_CNT);
  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(SEARCH_TIMEOUT);
  localparam logic [GAP_W-1:0]   GAP_MAX   = GAP_W'(LOSS_TIMEOUT);

  localparam logic ST_SEARCH = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  localparam logic [9:0] TOK_C00 = 10'b1101010100;
  localparam logic [9:0] TOK_C01 = 10'b0010101011;
  localparam logic [9:0] TOK_C10 = 10'b0101010100;
  localparam logic [9:0] TOK_C11 = 10'b1010101011;

  function automatic logic tok_hit(input logic [9:0] w);
    tok_hit = (w == TOK_C00) || (w == TOK_C01) || (w == TOK_C10) || (w == TOK_C11);
  endfunction

  function automatic logic [1:0] tok_ctrl(input logic [9:0] w);
    case (w)
      TOK_C01: tok_ctrl = 2'b01;
      TOK_C10: tok_ctrl = 2'b10;
      TOK_C11: tok_ctrl = 2'b11;
      default: tok_ctrl = 2'b00;
    endcase
  endfunction

  // Undo optional inversion (bit 9) then the XOR/XNOR chain selected by bit 8.
  function automatic logic [7:0] dec_data(input logic [9:0] w);
    logic [7:0] q;
    logic [7:0] d;
    q    = w[9] ? ~w[7:0] : w[7:0];
    d[0] = q[0];
    for (int unsigned i = 1; i < 8; i++) begin
      d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    dec_data = d;
  endfunction

  logic                state_q, state_d;
  logic [3:0]          offset_q, offset_d, offset_inc;
  logic [TOK_W-1:0]    tok_q, tok_d, tok_inc;
  logic [DWELL_W-1:0]  dwell_q, dwell_d, dwell_inc;
  logic [GAP_W-1:0]    gap_q, gap_d, gap_inc;
  logic [9:0]          sym_prev_q;
  logic [9:0]          s1_word_q;
  logic                s1_lock_q;
  logic [7:0]          data_q;
  logic [1:0]          ctrl_q;
  logic                de_q, out_valid_q;
  logic [18:0]         window;
  logic [9:0]          aligned;
  logic                aligned_tok;

  // Offset never exceeds 9, so sym_in[9] only ever reaches the aligner via sym_prev.
  assign window = {sym_in[8:0], sym_prev_q};

  always_comb begin
    aligned = window[9:0];
    for (int unsigned i = 0; i < 10; i++) begin
      if (offset_q == 4'(i)) aligned = window[i +: 10];
    end
  end

  assign aligned_tok = tok_hit(aligned);

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    tok_d      = tok_q;
    dwell_d    = dwell_q;
    gap_d      = gap_q;
    tok_inc    = (tok_q == TOK_MAX) ? tok_q : tok_q + 1'b1;
    dwell_inc  = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 1'b1;
    gap_inc    = (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;
    offset_inc = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
    if (sym_valid) begin
      case (state_q)
        ST_SEARCH: begin
          // Lock takes priority over a coincident dwell timeout.
          if (aligned_tok && (tok_inc == TOK_MAX)) begin
            state_d = ST_LOCKED;
            tok_d   = '0;
            dwell_d = '0;
          end else if (dwell_inc == DWELL_MAX) begin
            offset_d = offset_inc;
            tok_d    = '0;
            dwell_d  = '0;
          end else begin
            tok_d   = aligned_tok ? tok_inc : '0;
            dwell_d = dwell_inc;
          end
        end
        default: begin
          if (aligned_tok) begin
            gap_d = '0;
          end else if (gap_inc == GAP_MAX) begin
            state_d  = ST_SEARCH;
            offset_d = offset_inc;
            gap_d    = '0;
            tok_d    = '0;
            dwell_d  = '0;
          end else begin
            gap_d = gap_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SEARCH;
      offset_q <= '0;
      tok_q    <= '0;
      dwell_q  <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      tok_q    <= tok_d;
      dwell_q  <= dwell_d;
      gap_q    <= gap_d;
    end
  end

  // Stage 1 captures the aligned word plus the lock state it was aligned under;
  // stage 2 decodes it, updating outputs only for symbols aligned while locked.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      sym_prev_q  <= '0;
      s1_word_q   <= '0;
      s1_lock_q   <= 1'b0;
      data_q      <= '0;
      ctrl_q      <= '0;
      de_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (sym_valid) begin
      sym_prev_q  <= sym_in;
      s1_word_q   <= aligned;
      s1_lock_q   <= (state_q == ST_LOCKED);
      out_valid_q <= s1_lock_q;
      if (s1_lock_q) begin
        if (tok_hit(s1_word_q)) begin
          de_q   <= 1'b0;
          ctrl_q <= tok_ctrl(s1_word_q);
          data_q <= '0;
        end else begin
          de_q   <= 1'b1;
          data_q <= dec_data(s1_word_q);
        end
      end
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign data      = data_q;
  assign ctrl      = ctrl_q;
  assign de        = de_q;
  assign out_valid = out_valid_q;
  assign locked    = (state_q == ST_LOCKED);
  assign offset    = offset_q;

endmodule
